mux_scan: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with a manual select mode and an automatic round-robin scan mode. It generalises the lab's 4:1 single-bit mux. Per-channel enable masking, a programmable dwell time, hold and channel-switch indication are added. It sits between multiple sensor/data sources and a single downstream consumer, such as a display driver or UART, in the FPGA lab designs.

---
 rtl/mux_scan_if.sv | 29 ++
 rtl/mux_scan.sv | 111 +++++++++++
 tb/tb_mux_scan.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mux_scan_if.sv
// Channel data, select/scan controls and registered mux outputs for mux_scan.
// The master drives the sources and controls; the slave (the mux) drives y and status.
interface mux_scan_if #(
  parameter int WIDTH = 1,
  parameter int CH    = 4
);
  localparam int SELW = $clog2(CH);

  logic [CH*WIDTH-1:0] w;
  logic [SELW-1:0]     sel;
  logic                mode;
  logic [CH-1:0]       en_mask;
  logic                hold;

  logic [WIDTH-1:0]    y;
  logic [SELW-1:0]     cur_sel;
  logic                y_valid;
  logic                ch_switch;

  modport master (
    output w, sel, mode, en_mask, hold,
    input  y, cur_sel, y_valid, ch_switch
  );

  modport slave (
    input  w, sel, mode, en_mask, hold,
    output y, cur_sel, y_valid, ch_switch
  );
endinterface

// File: rtl/mux_scan.sv
// N-channel registered mux with manual select and round-robin auto scan (dwell, hold, mask).
// One cycle from any input change to y/cur_sel/y_valid; no backpressure, output updates every cycle.
module mux_scan #(
  parameter int WIDTH = 1,
  parameter int CH    = 4,
  parameter int DWELL = 100
) (
  input  logic       clk,
  input  logic       rst,
  mux_scan_if.slave  bus
);
  localparam int SELW = $clog2(CH);
  localparam int CNTW = $clog2(DWELL) + 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);

  logic [SELW-1:0]  cur_q;
  logic [CNTW-1:0]  cnt_q;
  logic [WIDTH-1:0] y_q;
  logic             vld_q;
  logic             sw_q;

  logic [SELW-1:0]  nxt_sel;
  logic [CNTW-1:0]  cnt_d;
  logic [WIDTH-1:0] y_d;
  logic             vld_d;
  logic             cur_en;

  logic [SELW-1:0]  first_en;
  logic [SELW-1:0]  up_en;
  logic             up_found;
  logic [SELW-1:0]  next_en;

  // Descending scan so the last hit is the lowest index: lowest enabled overall,
  // and lowest enabled strictly above the current channel.
  always_comb begin
    first_en = cur_q;
    up_en    = cur_q;
    up_found = 1'b0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (bus.en_mask[i]) begin
        first_en = SELW'(i);
        if (i > int'(cur_q)) begin
          up_en    = SELW'(i);
          up_found = 1'b1;
        end
      end
    end
    next_en = up_found ? up_en : first_en;
  end

  always_comb begin
    cur_en = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (cur_q == SELW'(i)) cur_en = bus.en_mask[i];
    end
  end

  // Selection rules; earlier branches take priority in auto mode.
  always_comb begin
    nxt_sel = cur_q;
    cnt_d   = cnt_q;
    if (!bus.mode) begin
      cnt_d = '0;
      if (int'(bus.sel) < CH) nxt_sel = bus.sel;
    end else if (bus.en_mask == '0) begin
      cnt_d = '0;
    end else if (!cur_en) begin
      nxt_sel = next_en;
      cnt_d   = '0;
    end else if (!bus.hold) begin
      if (cnt_q < CNT_LAST) begin
        cnt_d = cnt_q + CNTW'(1);
      end else begin
        nxt_sel = next_en;
        cnt_d   = '0;
      end
    end
  end

  always_comb begin
    y_d   = '0;
    vld_d = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (nxt_sel == SELW'(i)) begin
        y_d   = bus.w[i*WIDTH +: WIDTH];
        vld_d = bus.en_mask[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q <= '0;
      cnt_q <= '0;
      y_q   <= '0;
      vld_q <= 1'b0;
      sw_q  <= 1'b0;
    end else begin
      cur_q <= nxt_sel;
      cnt_q <= cnt_d;
      y_q   <= y_d;
      vld_q <= vld_d;
      sw_q  <= (nxt_sel != cur_q);
    end
  end

  assign bus.y         = y_q;
  assign bus.cur_sel   = cur_q;
  assign bus.y_valid   = vld_q;
  assign bus.ch_switch = sw_q;
endmodule

// File: tb/tb_mux_scan.sv
// Scoreboarded bench for mux_scan (CH=5, non power of two): directed scenarios then random traffic.
module tb_mux_scan;
  localparam int WIDTH = 4;
  localparam int CH    = 5;
  localparam int DWELL = 3;
  localparam int SELW  = $clog2(CH);

  logic clk = 1'b0;
  logic rst;

  mux_scan_if #(.WIDTH(WIDTH), .CH(CH)) bus();

  mux_scan #(.WIDTH(WIDTH), .CH(CH), .DWELL(DWELL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic [SELW-1:0]  cur;
    logic             vld;
    logic             sw;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   passed = 0;

  // Reference state: which channel is shown and how long it has been shown.
  int m_cur = 0;
  int m_cnt = 0;

  function automatic int next_enabled(input int c);
    for (int k = 1; k <= CH; k++) begin
      if (bus.en_mask[(c + k) % CH]) return (c + k) % CH;
    end
    return c;
  endfunction

  task automatic push_expected();
    exp_t e;
    int nxt;
    logic [CH*WIDTH-1:0] sh;
    if (rst) begin
      m_cur = 0;
      m_cnt = 0;
      e = '0;
    end else begin
      nxt = m_cur;
      if (!bus.mode) begin
        m_cnt = 0;
        if (int'(bus.sel) < CH) nxt = int'(bus.sel);
      end else if (bus.en_mask == '0) begin
        m_cnt = 0;
      end else if (!bus.en_mask[m_cur]) begin
        nxt = next_enabled(m_cur);
        m_cnt = 0;
      end else if (bus.hold) begin
        nxt = m_cur;
      end else if (m_cnt == DWELL - 1) begin
        nxt = next_enabled(m_cur);
        m_cnt = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
      sh    = bus.w >> (nxt * WIDTH);
      e.y   = sh[WIDTH-1:0];
      e.cur = SELW'(nxt);
      e.vld = bus.en_mask[nxt];
      e.sw  = (nxt != m_cur);
      m_cur = nxt;
    end
    expq.push_back(e);
  endtask

  task automatic drive(input logic r, input logic m, input logic h,
                       input logic [CH-1:0] msk, input logic [SELW-1:0] s,
                       input logic [CH*WIDTH-1:0] wd);
    rst         = r;
    bus.mode    = m;
    bus.hold    = h;
    bus.en_mask = msk;
    bus.sel     = s;
    bus.w       = wd;
    push_expected();
    @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  // Monitor: the DUT presents a new output after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("y",         int'(bus.y),         int'(e.y));
        check("cur_sel",   int'(bus.cur_sel),   int'(e.cur));
        check("y_valid",   int'(bus.y_valid),   int'(e.vld));
        check("ch_switch", int'(bus.ch_switch), int'(e.sw));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

  initial begin
    logic [CH*WIDTH-1:0] w0;
    logic [CH*WIDTH-1:0] wr;
    w0 = 20'h3D2A5;

    repeat (3) drive(1'b1, 1'b0, 1'b0, '1, '0, w0);

    // Manual routing, out-of-range select, disabled channel still routed
    for (int s = 0; s < CH; s++) repeat (4) drive(1'b0, 1'b0, 1'b0, '1, SELW'(s), w0);
    repeat (3) drive(1'b0, 1'b0, 1'b0, '1, SELW'(6), w0);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 5'b11101, SELW'(1), w0);
    drive(1'b0, 1'b0, 1'b0, '1, SELW'(0), w0);

    // Auto scan, all enabled
    repeat (20) drive(1'b0, 1'b1, 1'b0, '1, '0, w0);

    // Masked scan, then drop the current channel from the mask
    repeat (12) drive(1'b0, 1'b1, 1'b0, 5'b01010, '0, w0);
    for (int k = 0; k < 10 && m_cur != 3; k++) drive(1'b0, 1'b1, 1'b0, 5'b01010, '0, w0);
    repeat (4) drive(1'b0, 1'b1, 1'b0, 5'b00010, '0, w0);

    // Empty mask freezes
    repeat (5) drive(1'b0, 1'b1, 1'b0, 5'b00000, '0, w0);

    // Hold mid-dwell, also a hold on a disabled channel is overridden
    for (int k = 0; k < 10 && m_cnt != 1; k++) drive(1'b0, 1'b1, 1'b0, '1, '0, w0);
    repeat (5) drive(1'b0, 1'b1, 1'b1, '1, '0, w0);
    repeat (4) drive(1'b0, 1'b1, 1'b0, '1, '0, w0);
    drive(1'b0, 1'b1, 1'b1, 5'b10001, '0, w0);

    // Reset mid-scan on channel 2
    for (int k = 0; k < 20 && m_cur != 2; k++) drive(1'b0, 1'b1, 1'b0, '1, '0, w0);
    drive(1'b1, 1'b1, 1'b0, '1, '0, w0);
    repeat (4) drive(1'b0, 1'b1, 1'b0, '1, '0, w0);

    // Auto to manual
    repeat (2) drive(1'b0, 1'b0, 1'b0, '1, SELW'(3), w0);
    repeat (2) drive(1'b0, 1'b1, 1'b0, '1, SELW'(3), w0);

    // Random traffic
    bus.en_mask = '1;
    for (int n = 0; n < 600; n++) begin
      logic [CH-1:0] msk;
      msk = bus.en_mask;
      if ($urandom_range(0, 9) == 0) msk = CH'($urandom);
      wr = (CH*WIDTH)'($urandom);
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) < 8),
            ($urandom_range(0, 9) < 2), msk, SELW'($urandom), wr);
    end

    @(posedge clk);
    #2;
    check("queue_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
